pc_fetch_sequencer: RTL and testbench
=====================================

// Module: pc_fetch_sequencer
// PURPOSE
// Sequences the program counter and instruction fetch for the MIPS core. Supports branch delay slots, instruction
// memory wait states, datapath stalls and halt-on-jump-to-zero. Sits between the instruction memory port and the
// decode/execute datapath, replacing ad-hoc next-PC logic with an explicit FSM.
// PARAMETERS
// RESET_VECTOR  32'hBFC0_0000  PC loaded on reset
// HALT_ADDR     32'h0000_0000  redirect target that ends execution
// PORTS
// clk                input   1   rising-edge clock
// reset              input   1   asynchronous, active-low reset (0 = in reset)
// instr_read         output  1   fetch request to instruction memory
// instr_address      output  32  fetch address (= pc_out)
// instr_waitrequest  input   1   memory not ready; request must be held
// instr_readdata     input   32  fetched word, valid when read=1 & waitrequest=0
// stall              input   1   datapath not ready to retire current instruction
// branch_taken       input   1   conditional branch of current instruction resolved taken
// branch_target      input   32  branch destination
// jump_req           input   1   J/JAL/JR/JALR of current instruction
// jump_target        input   32  jump destination
// instr_out          output  32  registered instruction held for datapath
// instr_valid        output  1   instr_out is executing this cycle
// pc_out             output  32  address of current/fetching instruction
// link_addr          output  32  pc_out + 8 (return address for JAL/JALR)
// active             output  1   1 until halt reached
// BEHAVIOUR
// - States: IDLE, FETCH, EXEC, HALT. Reset (async, reset=0): state=IDLE, pc_out=RESET_VECTOR, instr_out=0,
//   delay_pend=0, tgt_reg=0, instr_read=0, instr_valid=0, active=1. link_addr = pc_out+8 combinationally.
// - IDLE: -> FETCH on first clk edge with reset=1.
// - FETCH: instr_read=1, instr_address=pc_out. If waitrequest=0 same cycle: capture readdata into instr_out, -> EXEC
//   next cycle (min fetch latency 1 cycle). If waitrequest=1: hold read and address stable, stay.
// - EXEC: instr_valid=1, instr_read=0. While stall=1: hold all state; branch/jump inputs ignored.
//   Retire cycle = EXEC with stall=0; on that edge -> FETCH with next pc chosen as:
//   * delay_pend=1 (current is delay slot): if tgt_reg==HALT_ADDR -> HALT, else pc_out<=tgt_reg; delay_pend<=0;
//     any redirect requested in a delay slot is ignored.
//   * else jump_req=1: tgt_reg<=jump_target, delay_pend<=1, pc_out<=pc_out+4 (fetch delay slot).
//   * else branch_taken=1: same using branch_target. jump_req has priority if both asserted.
//   * else pc_out<=pc_out+4.
// - Targets: bits [1:0] forced to 00 when latched. PC arithmetic modulo 2^32 (0xFFFF_FFFC+4 -> 0x0000_0000, no halt;
//   halt only via redirect).
// - HALT: active=0, instr_read=0, instr_valid=0, pc_out frozen at delay-slot address; exits only by reset.
// - Reset asserted mid-fetch or mid-stall: immediate return to reset values; no pending redirect survives.
// TESTING
// - Reset/linear: release reset, waitrequest=0, no redirects -> fetch addresses BFC00000, BFC00004, BFC00008, each
//   instr_valid 1 cycle; instr_read low in IDLE.
// - Wait states: waitrequest=1 for 3 cycles at BFC00000 -> instr_read/address held 3 cycles, EXEC 1 cycle after drop.
// - Delay slot: jump_req=1, jump_target=BFC00103 at PC BFC00010 -> next fetch BFC00014, then BFC00100.
// - Halt: JR to 0 at BFC00020 -> delay slot BFC00024 executes, then active=0, no further instr_read, pc_out=BFC00024.
// - Stall/priority: stall=1 for 2 EXEC cycles with branch_taken pulsed -> ignored; retire with both branch_taken
//   (target A0) and jump_req (target B0) -> jump to B0 after slot; redirect in slot ignored.
// - Async reset: drop reset mid-WAIT with delay_pend=1 -> outputs return to reset values without a clock edge.

Source files
------------

// File: rtl/pc_fetch_sequencer.sv
// Program-counter and instruction-fetch sequencer for the MIPS core: one instruction in flight,
// branch delay slots, memory wait states, datapath stalls and halt on a redirect to HALT_ADDR.
module pc_fetch_sequencer #(
    parameter logic [31:0] RESET_VECTOR = 32'hBFC0_0000,
    parameter logic [31:0] HALT_ADDR    = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        reset,
    output logic        instr_read,
    output logic [31:0] instr_address,
    input  logic        instr_waitrequest,
    input  logic [31:0] instr_readdata,
    input  logic        stall,
    input  logic        branch_taken,
    input  logic [31:0] branch_target,
    input  logic        jump_req,
    input  logic [31:0] jump_target,
    output logic [31:0] instr_out,
    output logic        instr_valid,
    output logic [31:0] pc_out,
    output logic [31:0] link_addr,
    output logic        active
);

    localparam logic [31:0] ALIGN_MASK = 32'hFFFF_FFFC;
    localparam logic [31:0] PC_STEP    = 32'd4;
    localparam logic [31:0] LINK_STEP  = 32'd8;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_FETCH = 2'd1,
        S_EXEC  = 2'd2,
        S_HALT  = 2'd3
    } state_t;

    state_t      state, state_nxt;
    logic [31:0] pc_q, pc_nxt;
    logic [31:0] instr_q, instr_nxt;
    logic        delay_pend, delay_pend_nxt;
    logic [31:0] tgt_reg, tgt_nxt;

    // NOTE: state registers use non-blocking assignments so every flop samples the
    // pre-edge value of every other flop, regardless of statement order.
    // NOTE: asynchronous reset clears every register, including the pending redirect,
    // so a reset in the middle of a wait or stall leaves nothing half-done behind.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state      <= S_IDLE;
            pc_q       <= RESET_VECTOR;
            instr_q    <= '0;
            delay_pend <= 1'b0;
            tgt_reg    <= '0;
        end else begin
            state      <= state_nxt;
            pc_q       <= pc_nxt;
            instr_q    <= instr_nxt;
            delay_pend <= delay_pend_nxt;
            tgt_reg    <= tgt_nxt;
        end
    end

    // NOTE: every signal written here gets a hold-value default first, so no path
    // through the case statement can leave one unassigned and infer a latch.
    always_comb begin
        state_nxt      = state;
        pc_nxt         = pc_q;
        instr_nxt      = instr_q;
        delay_pend_nxt = delay_pend;
        tgt_nxt        = tgt_reg;

        case (state)
            S_IDLE: begin
                state_nxt = S_FETCH;
            end

            S_FETCH: begin
                if (!instr_waitrequest) begin
                    instr_nxt = instr_readdata;
                    state_nxt = S_EXEC;
                end
            end

            S_EXEC: begin
                // A stalled instruction has not retired, so its redirect inputs are not yet meaningful.
                if (!stall) begin
                    state_nxt = S_FETCH;
                    if (delay_pend) begin
                        // Delay slot retiring: take the saved redirect, ignore any new one.
                        delay_pend_nxt = 1'b0;
                        if (tgt_reg == HALT_ADDR) begin
                            state_nxt = S_HALT;
                        end else begin
                            pc_nxt = tgt_reg;
                        end
                    end else if (jump_req) begin
                        tgt_nxt        = jump_target & ALIGN_MASK;
                        delay_pend_nxt = 1'b1;
                        pc_nxt         = pc_q + PC_STEP;
                    end else if (branch_taken) begin
                        tgt_nxt        = branch_target & ALIGN_MASK;
                        delay_pend_nxt = 1'b1;
                        pc_nxt         = pc_q + PC_STEP;
                    end else begin
                        pc_nxt = pc_q + PC_STEP;
                    end
                end
            end

            S_HALT: begin
                state_nxt = S_HALT;
            end

            default: begin
                state_nxt = S_IDLE;
            end
        endcase
    end

    // Outputs decode straight from registered state, so they follow an async reset immediately.
    assign instr_read    = (state == S_FETCH);
    assign instr_valid   = (state == S_EXEC);
    assign active        = (state != S_HALT);
    assign instr_address = pc_q;
    assign pc_out        = pc_q;
    assign instr_out     = instr_q;
    assign link_addr     = pc_q + LINK_STEP;

endmodule

// File: tb/tb_pc_fetch_sequencer.sv
// Bench for pc_fetch_sequencer: a table of per-instruction vectors driven cycle by cycle, with a
// fetch-address / instruction-word scoreboard, plus hand sequences for halt and async reset.
module tb_pc_fetch_sequencer;

    localparam logic [31:0] RV = 32'hBFC0_0000;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        instr_read;
    logic [31:0] instr_address;
    logic        instr_waitrequest = 1'b0;
    logic [31:0] instr_readdata;
    logic        stall = 1'b0;
    logic        branch_taken = 1'b0;
    logic [31:0] branch_target = '0;
    logic        jump_req = 1'b0;
    logic [31:0] jump_target = '0;
    logic [31:0] instr_out;
    logic        instr_valid;
    logic [31:0] pc_out;
    logic [31:0] link_addr;
    logic        active;

    int errors = 0;
    int checks = 0;

    logic [31:0] addr_q[$];
    logic [31:0] data_q[$];

    typedef struct {
        int          waits;
        int          stalls;
        logic        jr;
        logic [31:0] jt;
        logic        br;
        logic [31:0] bt;
        logic [31:0] addr;
    } vec_t;

    vec_t vecs[20];

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return {a[15:0], ~a[31:16]};
    endfunction

    function automatic vec_t mk(input int waits, input int stalls, input logic jr, input logic [31:0] jt,
                                input logic br, input logic [31:0] bt, input logic [31:0] addr);
        vec_t v;
        v.waits  = waits;
        v.stalls = stalls;
        v.jr     = jr;
        v.jt     = jt;
        v.br     = br;
        v.bt     = bt;
        v.addr   = addr;
        return v;
    endfunction

    pc_fetch_sequencer dut (
        .clk               (clk),
        .reset             (reset),
        .instr_read        (instr_read),
        .instr_address     (instr_address),
        .instr_waitrequest (instr_waitrequest),
        .instr_readdata    (instr_readdata),
        .stall             (stall),
        .branch_taken      (branch_taken),
        .branch_target     (branch_target),
        .jump_req          (jump_req),
        .jump_target       (jump_target),
        .instr_out         (instr_out),
        .instr_valid       (instr_valid),
        .pc_out            (pc_out),
        .link_addr         (link_addr),
        .active            (active)
    );

    always #5 clk = ~clk;

    assign instr_readdata = mem_word(instr_address);

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic check_bit(input string name, input logic act, input logic exp);
        check(name, {31'b0, act}, {31'b0, exp});
    endtask

    task automatic fail_now(input string name);
        checks++;
        errors++;
        $display("FAIL %s at %0t", name, $time);
    endtask

    // Runs after the inputs for the coming edge are driven: an accepted fetch pops the expected
    // address; an executing instruction is compared with the word the model fetched for it.
    task automatic monitor();
        logic [31:0] e;
        if (instr_read && !instr_waitrequest) begin
            if (addr_q.size() == 0) begin
                fail_now("fetch_unexpected");
            end else begin
                e = addr_q.pop_front();
                check("fetch_addr", instr_address, e);
                data_q.push_back(mem_word(e));
            end
        end
        if (instr_valid) begin
            if (data_q.size() == 0) begin
                fail_now("exec_unexpected");
            end else begin
                check("instr_out", instr_out, data_q[0]);
                if (!stall) void'(data_q.pop_front());
            end
        end
    endtask

    task automatic cycle(input logic wr, input logic st, input logic jr, input logic [31:0] jt,
                         input logic br, input logic [31:0] bt);
        @(negedge clk);
        instr_waitrequest = wr;
        stall             = st;
        jump_req          = jr;
        jump_target       = jt;
        branch_taken      = br;
        branch_target     = bt;
        monitor();
    endtask

    task automatic run_row(input vec_t v);
        addr_q.push_back(v.addr);
        for (int w = 0; w < v.waits; w++) begin
            cycle(1'b1, 1'b0, 1'b0, '0, 1'b0, '0);
            check_bit("wait_read", instr_read, 1'b1);
            check("wait_addr", instr_address, v.addr);
        end
        cycle(1'b0, 1'b0, 1'b0, '0, 1'b0, '0);
        check_bit("fetch_read", instr_read, 1'b1);
        check_bit("fetch_valid", instr_valid, 1'b0);
        for (int s = 0; s < v.stalls; s++) begin
            cycle(1'b0, 1'b1, 1'b0, '0, (s == 0), 32'hDEAD_0000);
            check_bit("stall_valid", instr_valid, 1'b1);
            check("stall_pc", pc_out, v.addr);
        end
        cycle(1'b0, 1'b0, v.jr, v.jt, v.br, v.bt);
        check_bit("exec_valid", instr_valid, 1'b1);
        check_bit("exec_read", instr_read, 1'b0);
        check_bit("exec_active", active, 1'b1);
        check("exec_pc", pc_out, v.addr);
        check("exec_link", link_addr, v.addr + 32'd8);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        // waits, stalls, jr, jt, br, bt, expected fetch address
        vecs[0]  = mk(3, 0, 0, '0,            0, '0,            32'hBFC0_0000);
        vecs[1]  = mk(0, 0, 0, '0,            0, '0,            32'hBFC0_0004);
        vecs[2]  = mk(1, 0, 0, '0,            0, '0,            32'hBFC0_0008);
        vecs[3]  = mk(0, 0, 0, '0,            0, '0,            32'hBFC0_000C);
        vecs[4]  = mk(0, 0, 1, 32'hBFC0_0103, 0, '0,            32'hBFC0_0010);
        vecs[5]  = mk(0, 0, 1, 32'h0000_0000, 0, '0,            32'hBFC0_0014);
        vecs[6]  = mk(0, 2, 1, 32'h0000_00B0, 1, 32'h0000_00A0, 32'hBFC0_0100);
        vecs[7]  = mk(0, 0, 0, '0,            1, 32'h0000_0300, 32'hBFC0_0104);
        vecs[8]  = mk(0, 0, 0, '0,            0, '0,            32'h0000_00B0);
        vecs[9]  = mk(0, 0, 0, '0,            1, 32'h0000_01C1, 32'h0000_00B4);
        vecs[10] = mk(0, 0, 0, '0,            0, '0,            32'h0000_00B8);
        vecs[11] = mk(0, 1, 0, '0,            0, '0,            32'h0000_01C0);
        vecs[12] = mk(0, 0, 1, 32'hFFFF_FFFC, 0, '0,            32'h0000_01C4);
        vecs[13] = mk(2, 0, 0, '0,            0, '0,            32'h0000_01C8);
        vecs[14] = mk(0, 0, 0, '0,            0, '0,            32'hFFFF_FFFC);
        vecs[15] = mk(0, 0, 0, '0,            0, '0,            32'h0000_0000);
        vecs[16] = mk(0, 0, 1, 32'hBFC0_0020, 0, '0,            32'h0000_0004);
        vecs[17] = mk(0, 0, 0, '0,            0, '0,            32'h0000_0008);
        vecs[18] = mk(0, 0, 1, 32'h0000_0000, 0, '0,            32'hBFC0_0020);
        vecs[19] = mk(0, 0, 0, '0,            0, '0,            32'hBFC0_0024);

        repeat (2) @(negedge clk);
        check_bit("rst_read", instr_read, 1'b0);
        check_bit("rst_valid", instr_valid, 1'b0);
        check_bit("rst_active", active, 1'b1);
        check("rst_pc", pc_out, RV);
        check("rst_instr", instr_out, 32'h0);
        check("rst_link", link_addr, RV + 32'd8);
        reset = 1'b1;
        check_bit("idle_read", instr_read, 1'b0);

        for (int i = 0; i < 20; i++) run_row(vecs[i]);

        // Delay slot at BFC00024 has retired with a saved target of zero: halt for good.
        for (int i = 0; i < 4; i++) begin
            cycle(1'b0, 1'b0, 1'b1, 32'h0000_1000, 1'b1, 32'h0000_2000);
            check_bit("halt_read", instr_read, 1'b0);
            check_bit("halt_valid", instr_valid, 1'b0);
            check_bit("halt_active", active, 1'b0);
            check("halt_pc", pc_out, 32'hBFC0_0024);
        end
        check("halt_addr_q_empty", addr_q.size(), 32'd0);
        check("halt_data_q_empty", data_q.size(), 32'd0);

        // Restart, then reset asynchronously while the delay-slot fetch is waiting.
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        check_bit("rst2_active", active, 1'b1);
        reset = 1'b1;
        run_row(mk(0, 0, 1, 32'hBFC0_0200, 0, '0, RV));
        addr_q.push_back(RV + 32'd4);
        cycle(1'b1, 1'b0, 1'b0, '0, 1'b0, '0);
        cycle(1'b1, 1'b0, 1'b0, '0, 1'b0, '0);
        check_bit("slot_wait_read", instr_read, 1'b1);
        #2;
        reset = 1'b0;
        #1;
        check_bit("async_read", instr_read, 1'b0);
        check_bit("async_valid", instr_valid, 1'b0);
        check_bit("async_active", active, 1'b1);
        check("async_pc", pc_out, RV);
        check("async_addr", instr_address, RV);
        check("async_instr", instr_out, 32'h0);
        check("async_link", link_addr, RV + 32'd8);
        addr_q.delete();
        data_q.delete();
        instr_waitrequest = 1'b0;
        @(negedge clk);
        reset = 1'b1;
        // A surviving redirect would send the second fetch to BFC00200.
        run_row(mk(0, 0, 0, '0, 0, '0, RV));
        run_row(mk(0, 0, 0, '0, 0, '0, RV + 32'd4));
        run_row(mk(1, 0, 0, '0, 0, '0, RV + 32'd8));
        check("end_addr_q_empty", addr_q.size(), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
